// File: rtl/imem_loader.sv
// Bootloader engine: receives a framed byte stream, assembles little-endian 32-bit words,
// writes them to instruction memory and releases the core only on a checksum-verified image.
module imem_loader #(
    parameter int          ADDR_W      = 12,
    parameter int          DEPTH_WORDS = 128,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int          CNT_W       = $clog2(DEPTH_WORDS) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              core_hold,
    output logic [CNT_W-1:0]  words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_LEN0, S_LEN1, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t             state, state_n;
    logic [15:0]        len;
    logic [CNT_W-1:0]   word_idx;
    logic [1:0]         byte_idx;
    logic [31:0]        word_buf;
    logic [7:0]         sum;

    logic               accept;
    logic               restart;
    logic [15:0]        n_len;
    logic               len_bad;
    logic               last_word;
    logic               chk_ok;

    assign accept    = rx_valid && rx_ready;
    assign restart   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign n_len     = {rx_data, len[7:0]};
    assign len_bad   = (n_len == 16'd0) || (n_len > 16'(DEPTH_WORDS));
    assign last_word = (16'(word_idx) == (len - 16'd1));
    assign chk_ok    = (8'(sum + rx_data) == 8'h00);

    assign done      = (state == S_DONE);
    assign error     = (state == S_ERROR);
    // A failed load keeps the core held so a partial image never executes.
    assign core_hold = busy || error;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n  = state;
        rx_ready = 1'b0;
        busy     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_n = S_SYNC;
            end
            S_SYNC: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept && (rx_data == SYNC_BYTE)) state_n = S_LEN0;
            end
            S_LEN0: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept) state_n = S_LEN1;
            end
            S_LEN1: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept) state_n = len_bad ? S_ERROR : S_DATA;
            end
            S_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept && (byte_idx == 2'd3) && last_word) state_n = S_CHECK;
            end
            S_CHECK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept) state_n = chk_ok ? S_DONE : S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (start) state_n = S_SYNC;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
            len          <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            sum          <= '0;
        end else begin
            mem_we <= 1'b0;
            if (restart) begin
                words_loaded <= '0;
                word_idx     <= '0;
                byte_idx     <= '0;
                sum          <= '0;
            end
            if (accept) begin
                case (state)
                    S_LEN0: len[7:0]  <= rx_data;
                    S_LEN1: len[15:8] <= rx_data;
                    S_DATA: begin
                        sum                    <= sum + rx_data;
                        word_buf[8*byte_idx +: 8] <= rx_data;
                        byte_idx               <= byte_idx + 2'd1;
                        // Fourth byte completes the word; the write strobe follows one cycle later.
                        if (byte_idx == 2'd3) begin
                            mem_we       <= 1'b1;
                            mem_addr     <= ADDR_W'({word_idx, 2'b00});
                            mem_wdata    <= {rx_data, word_buf[23:0]};
                            words_loaded <= words_loaded + CNT_W'(1);
                            if (!last_word) word_idx <= word_idx + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes go into a scoreboard queue
// that a negedge monitor drains whenever the DUT strobes mem_we.
module tb_imem_loader;

    localparam int ADDR_W      = 12;
    localparam int DEPTH_WORDS = 128;
    localparam int CNT_W       = $clog2(DEPTH_WORDS) + 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              error;
    logic              core_hold;
    logic [CNT_W-1:0]  words_loaded;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_data_q[$];
    logic [7:0]        frm[12];

    always #5 clk = ~clk;

    imem_loader #(
        .ADDR_W(ADDR_W),
        .DEPTH_WORDS(DEPTH_WORDS),
        .SYNC_BYTE(8'hA5),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .busy(busy),
        .done(done),
        .error(error),
        .core_hold(core_hold),
        .words_loaded(words_loaded)
    );

    // Write monitor: every strobe must match the next queued expectation.
    always @(negedge clk) begin : monitor
        logic [ADDR_W-1:0] ea;
        logic [31:0]       ed;
        if (mem_we === 1'b1) begin
            n_checks++;
            if (exp_addr_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         mem_addr, mem_wdata);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                if ((mem_addr !== ea) || (mem_wdata !== ed)) begin
                    n_fail++;
                    $display("FAIL mem_write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                             mem_addr, mem_wdata, ea, ed);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_start);
        bit acc = 1'b0;
        int cyc = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        start    = with_start;
        while (!acc && cyc < 50) begin
            @(negedge clk);
            acc = rx_ready;
            tick();
            start = 1'b0;
            cyc++;
        end
        rx_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_accept: got no rx_ready for byte 0x%0h, expected acceptance", b);
        end
    endtask

    task automatic send_frame(input logic [7:0] chk, input int gap, input int start_at);
        for (int i = 0; i < 12; i++) begin
            send_byte((i == 11) ? chk : frm[i], i == start_at);
            repeat (gap) tick();
        end
    endtask

    task automatic push_t1();
        exp_addr_q.push_back(12'h000); exp_data_q.push_back(32'h0000_0013);
        exp_addr_q.push_back(12'h004); exp_data_q.push_back(32'h2000_05B7);
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"}, done, 1);
        check({tag, "_error"}, error, 0);
        check({tag, "_core_hold"}, core_hold, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_words"}, words_loaded, 2);
    endtask

    initial begin
        frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB7,
                8'h05, 8'h00, 8'h20, 8'h11};
        reset_n  = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick();
        tick();
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_busy", busy, 0);
        check("rst_core_hold", core_hold, 0);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_words", words_loaded, 0);
        reset_n = 1'b1;
        tick();
        check("idle_rx_ready", rx_ready, 0);

        // Test 1: basic two-word image
        push_t1();
        pulse_start();
        check("t1_busy", busy, 1);
        check("t1_core_hold", core_hold, 1);
        send_frame(8'h11, 0, -1);
        check_done("t1");
        check("t1_addr_hold", mem_addr, 12'h004);
        check("t1_wdata_hold", mem_wdata, 32'h2000_05B7);

        // Test 2: junk before sync; start with final CHK byte is ignored
        push_t1();
        pulse_start();
        check("t2_words_cleared", words_loaded, 0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h5A, 1'b0);
        check("t2_still_sync_busy", busy, 1);
        check("t2_still_sync_ready", rx_ready, 1);
        send_frame(8'h11, 0, 11);
        check_done("t2");

        // Test 3: bad checksum, writes still land
        push_t1();
        pulse_start();
        send_frame(8'h12, 0, -1);
        check("t3_error", error, 1);
        check("t3_done", done, 0);
        check("t3_core_hold", core_hold, 1);
        check("t3_words", words_loaded, 2);
        check("t3_rx_ready", rx_ready, 0);

        // Test 4: length 129 exceeds depth
        pulse_start();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h81, 1'b0);
        send_byte(8'h00, 1'b0);
        check("t4_error", error, 1);
        check("t4_done", done, 0);
        check("t4_rx_ready", rx_ready, 0);
        check("t4_core_hold", core_hold, 1);
        check("t4_words", words_loaded, 0);

        // Test 5: 3-cycle rx_valid gaps between bytes
        push_t1();
        pulse_start();
        send_frame(8'h11, 3, -1);
        check_done("t5");

        // Test 6: reset mid-load, then start during busy is ignored
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(frm[i], 1'b0);
        reset_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_core_hold", core_hold, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_error", error, 0);
        check("t6_rst_we", mem_we, 0);
        check("t6_rst_words", words_loaded, 0);
        check("t6_rst_addr", mem_addr, 0);
        check("t6_rst_wdata", mem_wdata, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        push_t1();
        pulse_start();
        send_frame(8'h11, 0, 5);
        check_done("t6");

        repeat (5) tick();
        check("scoreboard_empty", exp_addr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
